// File: rtl/mem_io_ctrl_if.sv
// Host request / memory bus bundle for mem_io_ctrl.
// The master modport is the sequencer. The slave modport is the host and
// memory side that drives requests and answers bus cycles.
interface mem_io_ctrl_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
);
    // host side
    logic              start_rd;
    logic              start_wr;
    logic              clear;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [11:0]       state;
    logic [DATA_W-1:0] rdata;
    logic              busy;
    logic              timeout_err;
    // memory side
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_cs;
    logic              mem_oe;
    logic              mem_we;
    logic              mem_ready;

    modport master (
        input  start_rd, start_wr, clear, addr, wdata, mem_rdata, mem_ready,
        output state, rdata, busy, timeout_err,
        output mem_addr, mem_wdata, mem_cs, mem_oe, mem_we
    );

    modport slave (
        output start_rd, start_wr, clear, addr, wdata, mem_rdata, mem_ready,
        input  state, rdata, busy, timeout_err,
        input  mem_addr, mem_wdata, mem_cs, mem_oe, mem_we
    );
endinterface

// File: rtl/mem_io_ctrl.sv
// Memory access sequencer. It runs single read or write transactions through
// fixed bus phases and waits for mem_ready with a timeout. The one-hot state
// is published for the hex display, and the last read word is held for the
// same display.
module mem_io_ctrl #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 255
) (
    input  logic           clk,
    input  logic           rst,
    mem_io_ctrl_if.master  bus
);
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);

    typedef enum logic [11:0] {
        IDLE       = 12'h001,
        READ_ST0   = 12'h002,
        READ_ST1   = 12'h004,
        READ_ST2   = 12'h008,
        READ_WAIT  = 12'h010,
        READ_DONE  = 12'h020,
        WRITE_ST0  = 12'h040,
        WRITE_ST1  = 12'h080,
        WRITE_ST2  = 12'h100,
        WRITE_ST3  = 12'h200,
        WRITE_ST4  = 12'h400,
        WRITE_WAIT = 12'h800
    } state_t;

    // Bus strobe masks over the one-hot state bits.
    localparam logic [11:0] CS_MASK = 12'hFDE; // read ST0..WAIT and all write states
    localparam logic [11:0] OE_MASK = 12'h01C; // READ_ST1, READ_ST2, READ_WAIT
    localparam logic [11:0] WE_MASK = 12'h300; // WRITE_ST2, WRITE_ST3

    state_t            state_q, state_next;
    logic [CNT_W-1:0]  cnt_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic              terr_q;
    logic              cs_q, oe_q, we_q;
    logic              take_rd, take_wr, capture, abort, cnt_clr, cnt_inc;
    logic              cs_next, oe_next, we_next;

    // Next-state and datapath control decode. The strobes come from the next state.
    always_comb begin
        // NOTE: every signal gets a default first, so no path leaves one unassigned and infers a latch.
        state_next = state_q;
        take_rd    = 1'b0;
        take_wr    = 1'b0;
        capture    = 1'b0;
        abort      = 1'b0;
        cnt_clr    = 1'b0;
        cnt_inc    = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start_rd) begin
                    state_next = READ_ST0;
                    take_rd    = 1'b1;
                end else if (bus.start_wr) begin
                    state_next = WRITE_ST0;
                    take_wr    = 1'b1;
                end
            end
            READ_ST0:  state_next = READ_ST1;
            READ_ST1:  state_next = READ_ST2;
            READ_ST2: begin
                state_next = READ_WAIT;
                cnt_clr    = 1'b1;
            end
            READ_WAIT: begin
                if (bus.mem_ready) begin
                    state_next = READ_DONE;
                    capture    = 1'b1;
                end else if (cnt_q == CNT_LAST) begin
                    state_next = IDLE;
                    abort      = 1'b1;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            READ_DONE: if (bus.clear) state_next = IDLE;
            WRITE_ST0: state_next = WRITE_ST1;
            WRITE_ST1: state_next = WRITE_ST2;
            WRITE_ST2: state_next = WRITE_ST3;
            WRITE_ST3: state_next = WRITE_ST4;
            WRITE_ST4: begin
                state_next = WRITE_WAIT;
                cnt_clr    = 1'b1;
            end
            WRITE_WAIT: begin
                if (bus.mem_ready) begin
                    state_next = IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    state_next = IDLE;
                    abort      = 1'b1;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            default: state_next = IDLE; // any non-one-hot encoding recovers to IDLE
        endcase
        cs_next = |(state_next & CS_MASK);
        oe_next = |(state_next & OE_MASK);
        we_next = |(state_next & WE_MASK);
    end

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments, so every flop samples pre-edge values.
        if (rst) state_q <= IDLE;
        else     state_q <= state_next;
    end

    // Request latches, read capture, sticky timeout flag, wait counter and registered strobes.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            terr_q  <= 1'b0;
            cnt_q   <= '0;
            cs_q    <= 1'b0;
            oe_q    <= 1'b0;
            we_q    <= 1'b0;
        end else begin
            if (take_rd || take_wr) begin
                addr_q <= bus.addr;
                terr_q <= 1'b0;
            end
            if (take_wr) wdata_q <= bus.wdata;
            if (capture) rdata_q <= bus.mem_rdata;
            if (abort)   terr_q  <= 1'b1;
            if (cnt_clr)                        cnt_q <= '0;
            else if (cnt_inc && cnt_q != CNT_MAX) cnt_q <= cnt_q + 1'b1;
            cs_q <= cs_next;
            oe_q <= oe_next;
            we_q <= we_next;
        end
    end

    assign bus.state       = state_q;
    assign bus.busy        = ~state_q[0];
    assign bus.rdata       = rdata_q;
    assign bus.timeout_err = terr_q;
    assign bus.mem_addr    = addr_q;
    assign bus.mem_wdata   = wdata_q;
    assign bus.mem_cs      = cs_q;
    assign bus.mem_oe      = oe_q;
    assign bus.mem_we      = we_q;
endmodule

// File: tb/tb_mem_io_ctrl.sv
// Directed bench for mem_io_ctrl, built with TIMEOUT=4.
// The bench drives inputs and samples outputs on the falling clock edge.
module tb_mem_io_ctrl;
    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    mem_io_ctrl_if #(.ADDR_W(8), .DATA_W(16)) bus ();

    mem_io_ctrl #(.ADDR_W(8), .DATA_W(16), .TIMEOUT(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    always #5 clk = ~clk;

    // Global time limit.
    initial begin
        #200000;
        $display("FAIL watchdog: got no_finish exp finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_bus(input string tag, input logic [11:0] st,
                             input logic cs, input logic oe, input logic we);
        check({tag, ".state"}, 32'(bus.state), 32'(st));
        check({tag, ".cs"},    32'(bus.mem_cs), 32'(cs));
        check({tag, ".oe"},    32'(bus.mem_oe), 32'(oe));
        check({tag, ".we"},    32'(bus.mem_we), 32'(we));
    endtask

    logic [11:0] wr_states [5] = '{12'h080, 12'h100, 12'h200, 12'h400, 12'h800};
    logic        wr_we     [5] = '{1'b0,    1'b1,    1'b1,    1'b0,    1'b0};

    initial begin
        rst           = 1'b1;
        bus.start_rd  = 1'b0;
        bus.start_wr  = 1'b0;
        bus.clear     = 1'b0;
        bus.addr      = '0;
        bus.wdata     = '0;
        bus.mem_rdata = '0;
        bus.mem_ready = 1'b0;
        @(negedge clk);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) tick();

        // reset / idle state
        check_bus("reset", 12'h001, 1'b0, 1'b0, 1'b0);
        check("reset.rdata", 32'(bus.rdata), 32'h0);
        check("reset.busy",  32'(bus.busy), 32'h0);
        check("reset.terr",  32'(bus.timeout_err), 32'h0);
        check("reset.maddr", 32'(bus.mem_addr), 32'h0);
        check("reset.mwdat", 32'(bus.mem_wdata), 32'h0);

        // read, ready after one wait cycle
        bus.start_rd = 1'b1;
        bus.addr     = 8'h3C;
        tick();
        bus.start_rd = 1'b0;
        bus.addr     = 8'h00;
        check_bus("rd0", 12'h002, 1'b1, 1'b0, 1'b0);
        check("rd0.maddr", 32'(bus.mem_addr), 32'h3C);
        check("rd0.busy",  32'(bus.busy), 32'h1);
        tick();
        check_bus("rd1", 12'h004, 1'b1, 1'b1, 1'b0);
        tick();
        check_bus("rd2", 12'h008, 1'b1, 1'b1, 1'b0);
        tick();
        check_bus("rdw", 12'h010, 1'b1, 1'b1, 1'b0);
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 16'hBEEF;
        tick();
        bus.mem_ready = 1'b0;
        bus.mem_rdata = 16'h0000;
        check_bus("rdd", 12'h020, 1'b0, 1'b0, 1'b0);
        check("rdd.rdata", 32'(bus.rdata), 32'hBEEF);
        check("rdd.maddr", 32'(bus.mem_addr), 32'h3C);
        // READ_DONE ignores new starts and holds until clear
        bus.start_rd = 1'b1;
        bus.start_wr = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rdd.hold", 32'(bus.state), 32'h020);
        end
        bus.start_rd = 1'b0;
        bus.start_wr = 1'b0;
        bus.clear    = 1'b1;
        tick();
        bus.clear = 1'b0;
        check_bus("rd.clr", 12'h001, 1'b0, 1'b0, 1'b0);
        check("rd.clr.rdata", 32'(bus.rdata), 32'hBEEF);

        // write, ready in WRITE_WAIT
        bus.start_wr = 1'b1;
        bus.addr     = 8'h05;
        bus.wdata    = 16'h1234;
        tick();
        bus.start_wr = 1'b0;
        bus.addr     = 8'h00;
        bus.wdata    = 16'h0000;
        check_bus("wr0", 12'h040, 1'b1, 1'b0, 1'b0);
        check("wr0.maddr", 32'(bus.mem_addr), 32'h05);
        check("wr0.mwdat", 32'(bus.mem_wdata), 32'h1234);
        for (int i = 0; i < 5; i++) begin
            tick();
            check_bus($sformatf("wr%0d", i + 1), wr_states[i], 1'b1, 1'b0, wr_we[i]);
            check($sformatf("wr%0d.mwdat", i + 1), 32'(bus.mem_wdata), 32'h1234);
        end
        bus.mem_ready = 1'b1;
        tick();
        bus.mem_ready = 1'b0;
        check_bus("wr.end", 12'h001, 1'b0, 1'b0, 1'b0);
        check("wr.end.terr", 32'(bus.timeout_err), 32'h0);

        // simultaneous start: read wins, write dropped
        bus.start_rd = 1'b1;
        bus.start_wr = 1'b1;
        bus.addr     = 8'h77;
        bus.wdata    = 16'hAAAA;
        tick();
        bus.start_rd = 1'b0;
        bus.start_wr = 1'b0;
        check_bus("both0", 12'h002, 1'b1, 1'b0, 1'b0);
        check("both.maddr", 32'(bus.mem_addr), 32'h77);
        check("both.mwdat", 32'(bus.mem_wdata), 32'h1234);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("both.we", 32'(bus.mem_we), 32'h0);
        end
        check("both.wait", 32'(bus.state), 32'h010);
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 16'h5A5A;
        tick();
        bus.mem_ready = 1'b0;
        check("both.done",  32'(bus.state), 32'h020);
        check("both.rdata", 32'(bus.rdata), 32'h5A5A);
        bus.clear = 1'b1;
        tick();
        bus.clear = 1'b0;
        check("both.idle", 32'(bus.state), 32'h001);

        // read timeout with TIMEOUT=4: four cycles in READ_WAIT
        bus.start_rd  = 1'b1;
        bus.addr      = 8'h11;
        bus.mem_rdata = 16'hFFFF;
        tick();
        bus.start_rd = 1'b0;
        tick();
        tick();
        tick();
        check("to.wait1", 32'(bus.state), 32'h010);
        for (int i = 2; i <= 4; i++) begin
            tick();
            check($sformatf("to.wait%0d", i), 32'(bus.state), 32'h010);
        end
        tick();
        check_bus("to.idle", 12'h001, 1'b0, 1'b0, 1'b0);
        check("to.terr",  32'(bus.timeout_err), 32'h1);
        check("to.rdata", 32'(bus.rdata), 32'h5A5A);
        check("to.busy",  32'(bus.busy), 32'h0);

        // new start clears the flag; reset mid-write in WRITE_ST3
        bus.start_wr = 1'b1;
        bus.addr     = 8'h22;
        bus.wdata    = 16'h0F0F;
        tick();
        bus.start_wr = 1'b0;
        check("clr.state", 32'(bus.state), 32'h040);
        check("clr.terr",  32'(bus.timeout_err), 32'h0);
        tick();
        tick();
        tick();
        check_bus("rst.pre", 12'h200, 1'b1, 1'b0, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_bus("rst.post", 12'h001, 1'b0, 1'b0, 1'b0);
        check("rst.maddr", 32'(bus.mem_addr), 32'h0);
        check("rst.mwdat", 32'(bus.mem_wdata), 32'h0);
        check("rst.rdata", 32'(bus.rdata), 32'h0);
        check("rst.busy",  32'(bus.busy), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
